// File: rtl/vga_timing_generator_pkg.sv
`default_nettype none
// ============================================================================
// vga_timing_generator_pkg -- shared modes, colour fills and default timing.
// Revision: 1.0
// ============================================================================
package vga_timing_generator_pkg;

    typedef enum logic [1:0] {
        VGA_MODE_PASS    = 2'd0,
        VGA_MODE_BARS    = 2'd1,
        VGA_MODE_CHECKER = 2'd2,
        VGA_MODE_BLACK   = 2'd3
    } vga_mode_e;

    localparam logic BLACK = 1'b0;
    localparam logic WHITE = 1'b1;

    // 640x480 @ 60 Hz
    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    function automatic logic in_window(input int value, input int lo, input int len);
        return (value >= lo) && (value < lo + len);
    endfunction

    function automatic logic checker_white(input int col, input int row);
        return ((col ^ row) & 32) != 0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ============================================================================
// vga_axis_counter -- enabled 0..TOTAL-1 wrapping counter for one raster axis.
// Revision: 1.0
// ============================================================================
module vga_axis_counter #(
    parameter int TOTAL = 800,
    parameter int WIDTH = $clog2(TOTAL)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Enable,
    output logic [WIDTH-1:0] oCount,
    output logic             oWrap
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_count <= '0;
        end else if (Enable) begin
            r_count <= oWrap ? '0 : r_count + 1'b1;
        end
    end

    assign oWrap  = (r_count == WIDTH'(TOTAL - 1));
    assign oCount = r_count;

endmodule
`default_nettype wire

// File: rtl/vga_timing_generator.sv
`default_nettype none
// ============================================================================
// vga_timing_generator -- parametrised raster timing, sync decode and test patterns.
// Revision: 1.0
// ============================================================================
module vga_timing_generator
    import vga_timing_generator_pkg::*;
#(
    parameter int H_VISIBLE  = DEF_H_VISIBLE,
    parameter int H_FRONT    = DEF_H_FRONT,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BACK     = DEF_H_BACK,
    parameter int V_VISIBLE  = DEF_V_VISIBLE,
    parameter int V_FRONT    = DEF_V_FRONT,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BACK     = DEF_V_BACK,
    parameter bit H_POLARITY = 1'b0,
    parameter bit V_POLARITY = 1'b0,
    parameter int COLOR_BITS = 1,
    parameter int BAR_WIDTH  = 80,
    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
    localparam int CW        = $clog2(H_TOTAL),
    localparam int RW        = $clog2(V_TOTAL)
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    Enable,
    input  logic [1:0]              iMode,
    input  logic [3*COLOR_BITS-1:0] iPixel,
    output logic [CW-1:0]           oColumn,
    output logic [RW-1:0]           oRow,
    output logic                    oHorizontalSync,
    output logic                    oVerticalSync,
    output logic [COLOR_BITS-1:0]   oRed,
    output logic [COLOR_BITS-1:0]   oGreen,
    output logic [COLOR_BITS-1:0]   oBlue,
    output logic                    oDisplayEnable,
    output logic                    oLineStart,
    output logic                    oFrameStart
);

    localparam int c_hs_start = H_VISIBLE + H_FRONT;
    localparam int c_vs_start = V_VISIBLE + V_FRONT;
    localparam int c_bar_pw   = (BAR_WIDTH > 1) ? $clog2(BAR_WIDTH) : 1;
    localparam int c_rgb_w    = 3 * COLOR_BITS;

    logic [CW-1:0]         w_col;
    logic [RW-1:0]         w_row;
    logic                  w_col_wrap;
    logic                  w_row_wrap;
    logic                  w_hsync_active;
    logic                  w_vsync_active;
    logic                  w_visible;
    vga_mode_e             w_mode_eff;
    logic [c_rgb_w-1:0]    w_pattern;

    logic                  r_at_origin;
    vga_mode_e             r_mode;
    logic [c_bar_pw-1:0]   r_bar_px;
    logic [2:0]            r_bar_idx;
    logic                  r_hsync;
    logic                  r_vsync;
    logic [c_rgb_w-1:0]    r_rgb;
    logic                  r_de;
    logic                  r_line_start;
    logic                  r_frame_start;

    vga_axis_counter #(
        .TOTAL (H_TOTAL),
        .WIDTH (CW)
    ) u_col_counter (
        .Clock  (Clock),
        .Reset  (Reset),
        .Enable (Enable),
        .oCount (w_col),
        .oWrap  (w_col_wrap)
    );

    vga_axis_counter #(
        .TOTAL (V_TOTAL),
        .WIDTH (RW)
    ) u_row_counter (
        .Clock  (Clock),
        .Reset  (Reset),
        .Enable (Enable & w_col_wrap),
        .oCount (w_row),
        .oWrap  (w_row_wrap)
    );

    // Tracks "counters are at (0,0)" without a second wide comparator.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_at_origin <= 1'b1;
        end else if (Enable) begin
            r_at_origin <= w_col_wrap & w_row_wrap;
        end
    end

    // Bar position for the current column; restarts with every line.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_bar_px  <= '0;
            r_bar_idx <= '0;
        end else if (Enable) begin
            if (w_col_wrap) begin
                r_bar_px  <= '0;
                r_bar_idx <= '0;
            end else if (r_bar_px == c_bar_pw'(BAR_WIDTH - 1)) begin
                r_bar_px  <= '0;
                r_bar_idx <= r_bar_idx + 1'b1;
            end else begin
                r_bar_px <= r_bar_px + 1'b1;
            end
        end
    end

    assign w_hsync_active = in_window(int'(w_col), c_hs_start, H_SYNC);
    assign w_vsync_active = in_window(int'(w_row), c_vs_start, V_SYNC);
    assign w_visible      = (int'(w_col) < H_VISIBLE) && (int'(w_row) < V_VISIBLE);

    // The pixel at (0,0) already uses the mode being latched, so a frame never mixes modes.
    always_comb begin
        w_mode_eff = r_at_origin ? vga_mode_e'(iMode) : r_mode;
        w_pattern  = {c_rgb_w{BLACK}};
        case (w_mode_eff)
            VGA_MODE_PASS:    w_pattern = iPixel;
            VGA_MODE_BARS:    w_pattern = {{COLOR_BITS{r_bar_idx[2]}},
                                           {COLOR_BITS{r_bar_idx[1]}},
                                           {COLOR_BITS{r_bar_idx[0]}}};
            VGA_MODE_CHECKER: w_pattern = checker_white(int'(w_col), int'(w_row)) ?
                                          {c_rgb_w{WHITE}} : {c_rgb_w{BLACK}};
            default:          w_pattern = {c_rgb_w{BLACK}};
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_hsync       <= ~H_POLARITY;
            r_vsync       <= ~V_POLARITY;
            r_rgb         <= '0;
            r_de          <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_mode        <= VGA_MODE_PASS;
        end else if (Enable) begin
            r_hsync       <= w_hsync_active ? H_POLARITY : ~H_POLARITY;
            r_vsync       <= w_vsync_active ? V_POLARITY : ~V_POLARITY;
            r_rgb         <= w_visible ? w_pattern : '0;
            r_de          <= w_visible;
            r_line_start  <= (w_col == '0);
            r_frame_start <= r_at_origin;
            if (r_at_origin) begin
                r_mode <= w_mode_eff;
            end
        end else begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end
    end

    assign oColumn         = w_col;
    assign oRow            = w_row;
    assign oHorizontalSync = r_hsync;
    assign oVerticalSync   = r_vsync;
    assign oRed            = r_rgb[3*COLOR_BITS-1:2*COLOR_BITS];
    assign oGreen          = r_rgb[2*COLOR_BITS-1:COLOR_BITS];
    assign oBlue           = r_rgb[COLOR_BITS-1:0];
    assign oDisplayEnable  = r_de;
    assign oLineStart      = r_line_start;
    assign oFrameStart     = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_generator.sv
`default_nettype none
// ============================================================================
// tb_vga_timing_generator -- directed self-checking bench on reduced raster sizes.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_vga_timing_generator;

    // Main instance: 128+8+16+8 = 160 columns, 40+2+2+4 = 48 rows.
    localparam int FRAME = 160 * 48;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic [5:0] pixel;

    logic [7:0] col;
    logic [5:0] row;
    logic       hs, vs, de, ls, fs;
    logic [1:0] red, grn, blu;
    logic [10:0] obs;

    logic [5:0] p_col;
    logic [3:0] p_row;
    logic       p_hs, p_vs, p_de, p_ls, p_fs, p_r, p_g, p_b;

    int errors = 0;
    int checks = 0;

    int         mc, mr;
    logic [1:0] mmode;
    logic [10:0] mexp;

    always #5 clk = ~clk;

    assign obs = {hs, vs, de, ls, fs, red, grn, blu};

    vga_timing_generator #(
        .H_VISIBLE(128), .H_FRONT(8), .H_SYNC(16), .H_BACK(8),
        .V_VISIBLE(40),  .V_FRONT(2), .V_SYNC(2),  .V_BACK(4),
        .H_POLARITY(1'b0), .V_POLARITY(1'b0), .COLOR_BITS(2), .BAR_WIDTH(16)
    ) u_dut (
        .Clock(clk), .Reset(rst_n), .Enable(en), .iMode(mode), .iPixel(pixel),
        .oColumn(col), .oRow(row), .oHorizontalSync(hs), .oVerticalSync(vs),
        .oRed(red), .oGreen(grn), .oBlue(blu), .oDisplayEnable(de),
        .oLineStart(ls), .oFrameStart(fs)
    );

    // Polarity instance: 32+4+8+4 = 48 columns, 8+1+2+1 = 12 rows, active-high syncs.
    vga_timing_generator #(
        .H_VISIBLE(32), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
        .V_VISIBLE(8),  .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .H_POLARITY(1'b1), .V_POLARITY(1'b1), .COLOR_BITS(1), .BAR_WIDTH(8)
    ) u_pol (
        .Clock(clk), .Reset(rst_n), .Enable(en), .iMode(mode), .iPixel(pixel[2:0]),
        .oColumn(p_col), .oRow(p_row), .oHorizontalSync(p_hs), .oVerticalSync(p_vs),
        .oRed(p_r), .oGreen(p_g), .oBlue(p_b), .oDisplayEnable(p_de),
        .oLineStart(p_ls), .oFrameStart(p_fs)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected {hs,vs,de,ls,fs,rgb} for the main instance given the counter that produced it.
    function automatic logic [10:0] exp_main(input int c, input int r, input logic [1:0] m,
                                             input logic [5:0] px);
        logic       e_hs, e_vs, e_de, e_ls, e_fs;
        logic [5:0] rgb;
        int         bi;
        e_hs = !((c >= 136) && (c < 152));
        e_vs = !((r >= 42) && (r < 44));
        e_de = (c < 128) && (r < 40);
        e_ls = (c == 0);
        e_fs = (c == 0) && (r == 0);
        rgb  = 6'd0;
        bi   = c / 16;
        if (e_de) begin
            case (m)
                2'd0: rgb = px;
                2'd1: rgb = {{2{bi[2]}}, {2{bi[1]}}, {2{bi[0]}}};
                2'd2: rgb = ((((c >> 5) ^ (r >> 5)) & 1) != 0) ? 6'h3f : 6'h00;
                default: rgb = 6'h00;
            endcase
        end
        return {e_hs, e_vs, e_de, e_ls, e_fs, rgb};
    endfunction

    task automatic model_reset();
        mc    = 0;
        mr    = 0;
        mmode = 2'd0;
        mexp  = {1'b1, 1'b1, 9'd0};
    endtask

    task automatic model_step(input logic e, input logic [1:0] m, input logic [5:0] px);
        if (e) begin
            if (mc == 0 && mr == 0) mmode = m;
            mexp = exp_main(mc, mr, mmode, px);
            if (mc == 159) begin
                mc = 0;
                mr = (mr == 47) ? 0 : mr + 1;
            end else begin
                mc = mc + 1;
            end
        end else begin
            mexp[7:6] = 2'b00;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; mode = 2'd0; pixel = 6'd0;
        tick();
        en = 1'b1;
        tick();
        tick();
        model_reset();
        checks++; if (col !== 8'd0)  begin errors++; $display("FAIL reset_col got %0d want 0", col); end
        checks++; if (row !== 6'd0)  begin errors++; $display("FAIL reset_row got %0d want 0", row); end
        checks++; if (hs !== 1'b1)   begin errors++; $display("FAIL reset_hsync got %b want 1", hs); end
        checks++; if (vs !== 1'b1)   begin errors++; $display("FAIL reset_vsync got %b want 1", vs); end
        checks++; if ({red, grn, blu} !== 6'd0) begin errors++; $display("FAIL reset_rgb got %h want 0", {red, grn, blu}); end
        checks++; if (de !== 1'b0)   begin errors++; $display("FAIL reset_de got %b want 0", de); end
        checks++; if ({ls, fs} !== 2'b00) begin errors++; $display("FAIL reset_strobes got %b want 00", {ls, fs}); end
        checks++; if ({p_hs, p_vs} !== 2'b00) begin errors++; $display("FAIL reset_pol_idle got %b want 00", {p_hs, p_vs}); end
    endtask

    task automatic test_pass_through();
        int bad = 0, fs_cnt = 0, fs_first = -1, fs_second = -1;
        int hs_low = 0, vs_low = 0, de_cnt = 0, leak = 0, first_hs_col = -1;
        logic [24:0] bad_got = '0, bad_exp = '0;
        rst_n = 1'b1; en = 1'b1; mode = 2'd0;
        for (int i = 0; i < 2 * FRAME + 1; i++) begin
            pixel = 6'(mc);
            model_step(en, mode, pixel);
            tick();
            if ({obs, col, row} !== {mexp, 8'(mc), 6'(mr)}) begin
                if (bad == 0) begin bad_got = {obs, col, row}; bad_exp = {mexp, 8'(mc), 6'(mr)}; end
                bad++;
            end
            if (fs === 1'b1) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = i; else if (fs_second < 0) fs_second = i;
            end
            if (i < 2 * FRAME) begin
                if (hs === 1'b0) hs_low++;
                if (vs === 1'b0) vs_low++;
                if (de === 1'b1) de_cnt++;
                if (de === 1'b0 && {red, grn, blu} !== 6'd0) leak++;
            end
            if (hs === 1'b0 && first_hs_col < 0) first_hs_col = int'(col);
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL pass_vectors bad=%0d got %h want %h", bad, bad_got, bad_exp); end
        checks++; if (fs_cnt !== 3) begin errors++; $display("FAIL pass_fs_count got %0d want 3", fs_cnt); end
        checks++; if (fs_second - fs_first !== FRAME) begin errors++; $display("FAIL pass_frame_period got %0d want %0d", fs_second - fs_first, FRAME); end
        checks++; if (hs_low !== 1536) begin errors++; $display("FAIL pass_hsync_low got %0d want 1536", hs_low); end
        checks++; if (vs_low !== 640)  begin errors++; $display("FAIL pass_vsync_low got %0d want 640", vs_low); end
        checks++; if (de_cnt !== 10240) begin errors++; $display("FAIL pass_de_count got %0d want 10240", de_cnt); end
        checks++; if (leak !== 0) begin errors++; $display("FAIL pass_blank_leak got %0d want 0", leak); end
        checks++; if (first_hs_col !== 137) begin errors++; $display("FAIL pass_hsync_start got col %0d want 137", first_hs_col); end
    endtask

    task automatic test_enable_toggle();
        int bad = 0, hold_bad = 0, fs_first = -1, fs_second = -1;
        logic [10:0] prev_obs;
        logic [13:0] prev_pos;
        rst_n = 1'b0; en = 1'b0;
        tick();
        model_reset();
        rst_n = 1'b1;
        for (int i = 0; i < 4 * FRAME + 1; i++) begin
            en       = (i % 2 == 0);
            pixel    = en ? 6'(mc) : 6'h2a;
            prev_obs = obs;
            prev_pos = {col, row};
            model_step(en, mode, pixel);
            tick();
            if ({obs, col, row} !== {mexp, 8'(mc), 6'(mr)}) bad++;
            if (!en) begin
                if ({obs[10:8], obs[5:0], col, row} !== {prev_obs[10:8], prev_obs[5:0], prev_pos}
                    || obs[7:6] !== 2'b00) hold_bad++;
            end
            if (fs === 1'b1) begin
                if (fs_first < 0) fs_first = i; else if (fs_second < 0) fs_second = i;
            end
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL toggle_vectors got %0d bad want 0", bad); end
        checks++; if (hold_bad !== 0) begin errors++; $display("FAIL toggle_hold got %0d unstable want 0", hold_bad); end
        checks++; if (fs_second - fs_first !== 2 * FRAME) begin errors++; $display("FAIL toggle_period got %0d want %0d", fs_second - fs_first, 2 * FRAME); end
    endtask

    task automatic test_pattern_modes();
        int bad = 0, phase = 0, pc, pr;
        logic [5:0] rgb;
        rst_n = 1'b0; en = 1'b0; mode = 2'd0;
        tick();
        model_reset();
        rst_n = 1'b1; en = 1'b1;
        for (int i = 0; i < 4 * FRAME && phase != 5; i++) begin
            if (phase == 0 && mr == 20) begin mode = 2'd1; phase = 1; end
            pc = mc; pr = mr;
            pixel = 6'(mc);
            model_step(en, mode, pixel);
            tick();
            rgb = {red, grn, blu};
            if ({obs, col, row} !== {mexp, 8'(mc), 6'(mr)}) bad++;
            if (phase == 1 && pc == 16 && pr == 21) begin
                checks++; if (rgb !== 6'd16) begin errors++; $display("FAIL bars_deferred got %h want 10", rgb); end
            end
            if (phase == 1 && fs === 1'b1) phase = 2;
            if (phase == 3 && fs === 1'b1) phase = 4;
            if (phase == 2 && pr == 0) begin
                if (pc == 0)   begin checks++; if (rgb !== 6'b000000) begin errors++; $display("FAIL bars_col0 got %b want 000000", rgb); end end
                if (pc == 16)  begin checks++; if (rgb !== 6'b000011) begin errors++; $display("FAIL bars_col16 got %b want 000011", rgb); end end
                if (pc == 112) begin checks++; if (rgb !== 6'b111111) begin errors++; $display("FAIL bars_col112 got %b want 111111", rgb); end end
                if (pc == 127) begin checks++; if (rgb !== 6'b111111) begin errors++; $display("FAIL bars_col127 got %b want 111111", rgb); end end
                if (pc == 128) begin checks++; if (rgb !== 6'b000000) begin errors++; $display("FAIL bars_blank got %b want 000000", rgb); end end
                if (pc == 159) begin mode = 2'd2; phase = 3; end
            end
            if (phase == 3 && pc == 16 && pr == 5) begin
                checks++; if (rgb !== 6'b000011) begin errors++; $display("FAIL checker_deferred got %b want 000011", rgb); end
            end
            if (phase == 4) begin
                if (pc == 0 && pr == 0)   begin checks++; if (rgb !== 6'h00) begin errors++; $display("FAIL checker_0_0 got %h want 00", rgb); end end
                if (pc == 32 && pr == 0)  begin checks++; if (rgb !== 6'h3f) begin errors++; $display("FAIL checker_32_0 got %h want 3f", rgb); end end
                if (pc == 0 && pr == 32)  begin checks++; if (rgb !== 6'h3f) begin errors++; $display("FAIL checker_0_32 got %h want 3f", rgb); end end
                if (pc == 32 && pr == 32) begin
                    checks++; if (rgb !== 6'h00) begin errors++; $display("FAIL checker_32_32 got %h want 00", rgb); end
                    phase = 5;
                end
            end
        end
        checks++; if (phase !== 5) begin errors++; $display("FAIL pattern_timeout got phase %0d want 5", phase); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL pattern_vectors got %0d bad want 0", bad); end
    endtask

    task automatic test_reset_midframe();
        mode = 2'd0; en = 1'b1; rst_n = 1'b1;
        for (int i = 0; i < 2 * FRAME && !(mr == 30 && mc == 100); i++) begin
            pixel = 6'(mc);
            model_step(en, mode, pixel);
            tick();
        end
        checks++; if ({col, row} !== {8'd100, 6'd30}) begin errors++; $display("FAIL midreset_reach got %0d,%0d want 100,30", col, row); end
        rst_n = 1'b0; en = 1'b0;
        tick();
        model_reset();
        checks++; if ({col, row} !== 14'd0) begin errors++; $display("FAIL midreset_counters got %0d,%0d want 0,0", col, row); end
        checks++; if ({hs, vs, de, fs} !== 4'b1100) begin errors++; $display("FAIL midreset_outputs got %b want 1100", {hs, vs, de, fs}); end
        rst_n = 1'b1;
        tick();
        checks++; if ({col, fs} !== 9'd0) begin errors++; $display("FAIL midreset_hold got col %0d fs %b want 0 0", col, fs); end
        en = 1'b1;
        tick();
        checks++; if ({fs, ls} !== 2'b11) begin errors++; $display("FAIL midreset_strobes got %b want 11", {fs, ls}); end
        checks++; if ({col, row} !== {8'd1, 6'd0}) begin errors++; $display("FAIL midreset_advance got %0d,%0d want 1,0", col, row); end
    endtask

    task automatic test_polarity();
        int bad = 0, first_hi = -1, hs_hi = 0, max_col = 0, pcm = 0, prm = 0;
        logic [7:0] pexp;
        logic e_de;
        rst_n = 1'b0; en = 1'b0; mode = 2'd0;
        tick();
        checks++; if ({p_hs, p_vs} !== 2'b00) begin errors++; $display("FAIL pol_idle got %b want 00", {p_hs, p_vs}); end
        rst_n = 1'b1; en = 1'b1;
        for (int i = 0; i < 48 * 12 + 1; i++) begin
            pixel = 6'(pcm * 5);
            e_de  = (pcm < 32) && (prm < 8);
            pexp  = {(pcm >= 36 && pcm < 44), (prm >= 9 && prm < 11), e_de,
                     (pcm == 0), (pcm == 0 && prm == 0), e_de ? pixel[2:0] : 3'b000};
            if (pcm == 47) begin pcm = 0; prm = (prm == 11) ? 0 : prm + 1; end
            else pcm = pcm + 1;
            tick();
            if ({p_hs, p_vs, p_de, p_ls, p_fs, p_r, p_g, p_b, p_col, p_row} !== {pexp, 6'(pcm), 4'(prm)}) bad++;
            if (p_hs === 1'b1 && first_hi < 0) first_hi = int'(p_col);
            if (i < 48 * 12 && p_hs === 1'b1) hs_hi++;
            if (int'(p_col) > max_col) max_col = int'(p_col);
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL pol_vectors got %0d bad want 0", bad); end
        checks++; if (first_hi !== 37) begin errors++; $display("FAIL pol_hsync_start got col %0d want 37", first_hi); end
        checks++; if (hs_hi !== 96) begin errors++; $display("FAIL pol_hsync_high got %0d want 96", hs_hi); end
        checks++; if (max_col !== 47) begin errors++; $display("FAIL pol_h_total got max col %0d want 47", max_col); end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_pass_through();
        test_enable_toggle();
        test_pattern_modes();
        test_reset_midframe();
        test_polarity();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
